program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning the instruction-memory size in bytes and the maximum load length.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: load request, sampled on the rising edge.
REQ-005 SHALL have port byte_count, input, 11 bits: number of bytes to load, sampled when start is accepted.
REQ-006 SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1): the byte-stream handshake.
REQ-007 SHALL have ports mem_we (output, 1), mem_addr (output, 32) and mem_wdata (output, 8): the instruction-memory byte write port.
REQ-008 SHALL have port cpu_reset, output, 1 bit: drives the processor's reset.
REQ-009 SHALL have ports busy, done and error, each output, 1 bit: status flags.
REQ-010 SHALL have port checksum, output, 32 bits: running sum of the loaded words.

Function
REQ-011 SHALL implement states IDLE, LOAD, DONE and ERR.
REQ-012 In IDLE, with start=1: byte_count in 4..MEM_BYTES and byte_count[1:0]==0 -> LOAD; otherwise -> ERR.
REQ-013 On entry to LOAD, SHALL clear the byte index, the word assembler and checksum.
REQ-014 SHALL drive in_ready=1 only in LOAD.
- A byte transfers only on a rising edge with in_valid && in_ready.
- No transfer occurs while in_valid=0, including mid-word stalls of any length.
REQ-015 For each transferred byte at index k, SHALL produce a registered write in the next cycle:
- mem_we=1, mem_addr=k, mem_wdata=byte.
- mem_we=0 in every other cycle.
REQ-016 SHALL send bytes to increasing addresses starting at 0, with no gaps or repeats.
REQ-017 SHALL assemble each group of 4 bytes big-endian (first byte into bits [31:24]).
REQ-018 SHALL update checksum as checksum + word, mod 2^32, in the cycle after the 4th byte of each word is accepted.
REQ-019 On acceptance of byte index byte_count-1, SHALL move to DONE on the next edge; in_ready=0 from then on, and the final mem_we occurs in the first DONE cycle.
REQ-020 SHALL drive cpu_reset=1 in IDLE, LOAD and ERR, and cpu_reset=0 only in DONE, so the processor leaves reset with pc=0 after the image is complete.
REQ-021 Status flags SHALL be:
- busy=1 only in LOAD.
- done=1 only in DONE.
- error=1 only in ERR.
REQ-022 start while in LOAD SHALL be ignored.
REQ-023 start while in DONE or ERR SHALL be evaluated as in IDLE (REQ-012), restarting a load; cpu_reset rises in that same transition cycle.
REQ-024 in_valid while not in LOAD SHALL be ignored, with no write and no state change.
REQ-025 SHALL hold checksum stable outside LOAD until the next accepted start.
REQ-026 Index counter width SHALL cover MEM_BYTES; mem_addr SHALL be the zero-extended index.

Reset
REQ-027 When reset=1 at a rising edge, including mid-LOAD, the block SHALL go to IDLE with:
- index, assembler and checksum = 0;
- mem_we=0, mem_addr=0, mem_wdata=0;
- in_ready=0, busy=0, done=0, error=0, cpu_reset=1.
REQ-028 reset SHALL take priority over start and in_valid in the same cycle.
REQ-029 A write pending from a byte accepted in the cycle before reset SHALL be suppressed.

Verification
REQ-030 Normal load:
- Stimulus: start with byte_count=8; stream 20 08 00 05 AC 08 00 00 with in_valid held high.
- Response: writes to addresses 0..7 in order; checksum=0x20080005 then 0xCC100005; done=1; cpu_reset=0.
REQ-031 Stalls:
- Stimulus: same stream as REQ-030, with in_valid deasserted for 3 cycles after byte 2 and 5 cycles after byte 5.
- Response: identical writes and checksum; no extra mem_we.
REQ-032 Bad count:
- Stimulus: start with byte_count=0, then 6, then 1028 (each from IDLE/ERR).
- Response: error=1; in_ready=0; no mem_we; cpu_reset stays 1.
REQ-033 Reset mid-load:
- Stimulus: reset asserted after byte 3 of an 8-byte load.
- Response: IDLE; checksum=0; no write for the pending byte.
- Stimulus: then a new 4-byte load.
- Response: writes start at address 0.
REQ-034 Ignored inputs:
- Stimulus: start during LOAD.
- Response: ignored, load completes normally.
- Stimulus: start in DONE with byte_count=4.
- Response: cpu_reset=1 in the transition cycle, new load to address 0, checksum restarts.
REQ-035 Full memory:
- Stimulus: byte_count=1024.
- Response: last write at mem_addr=1023; done=1.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//   in_valid/in_data/in_ready : byte stream (source -> loader)
//   mem_we/mem_addr/mem_wdata : byte write into instruction memory (loader -> memory)
// master : the stream source / memory side (testbench or system)
// slave  : the loader
interface program_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: streams byte_count bytes into instruction memory starting at
// address 0, keeps a 32-bit checksum of the big-endian words, and holds the CPU
// in reset until the image is complete.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start           : load request (evaluated in IDLE/DONE/ERR)
//   byte_count      : bytes to load, multiple of 4 in 4..MEM_BYTES
//   bus (slave)     : byte stream in, memory byte write out
//   cpu_reset       : low only once the image has been loaded
//   busy/done/error : status flags for LOAD/DONE/ERR
//   checksum        : running sum of loaded words, mod 2^32
module program_loader #(
    parameter int MEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [10:0]        byte_count,
    program_loader_if.slave    bus,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [31:0]        checksum
);
    // Index must be able to hold MEM_BYTES-1; the extra bit also covers MEM_BYTES.
    localparam int IW = $clog2(MEM_BYTES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  last_idx;
    logic [23:0]    asm_q;      // first three bytes of the current word
    logic           count_ok;
    logic [31:0]    word;

    assign count_ok = (byte_count >= 11'd4) &&
                      (32'(byte_count) <= 32'(MEM_BYTES)) &&
                      (byte_count[1:0] == 2'b00);

    // Completed word when the 4th byte is on the bus
    assign word = {asm_q, bus.in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            last_idx      <= '0;
            asm_q         <= '0;
            checksum      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.in_ready  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_reset     <= 1'b1;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                LOAD: begin
                    // start is ignored here; only the stream advances the load
                    if (bus.in_valid && bus.in_ready) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= 32'(idx);
                        bus.mem_wdata <= bus.in_data;
                        idx           <= idx + IW'(1);
                        asm_q         <= {asm_q[15:0], bus.in_data};
                        if (idx[1:0] == 2'b11)
                            checksum <= checksum + word;
                        if (idx == last_idx) begin
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            cpu_reset    <= 1'b0;
                        end
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all treat start the same way
                    if (start) begin
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        if (count_ok) begin
                            state        <= LOAD;
                            idx          <= '0;
                            asm_q        <= '0;
                            checksum     <= '0;
                            last_idx     <= IW'(byte_count - 11'd1);
                            bus.in_ready <= 1'b1;
                            busy         <= 1'b1;
                            error        <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal load, stalls, bad counts, reset
// mid-load, ignored start, restart from DONE and a full-memory load.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] byte_count;
    logic        cpu_reset, busy, done, error;
    logic [31:0] checksum;

    program_loader_if bus ();

    program_loader #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_count (byte_count),
        .bus        (bus),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Write log captured away from the active edge
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    logic [7:0]  exp_q[$];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic start_load(input logic [10:0] n);
        start      = 1'b1;
        byte_count = n;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Presents a byte and returns at the negedge after it was accepted;
    // in_valid is left high so consecutive calls stream back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready never rose (waited %0d, required <50)", n);
        end
        @(negedge clk);
    endtask

    task automatic stall(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_log(input string tag, input int n);
        int bad;
        bad = 0;
        chk({tag, "_count"}, 32'(wa.size()), 32'(n));
        for (int i = 0; i < wa.size() && i < n; i++)
            if (wa[i] !== 32'(i) || wd[i] !== exp_q[i]) bad++;
        chk({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] w, sum;
        reset        = 1'b1;
        start        = 1'b0;
        byte_count   = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_flags", {28'd0, busy, done, error, bus.in_ready}, 32'd0);
        chk("rst_mem", {bus.mem_we, bus.mem_addr[22:0], bus.mem_wdata}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Normal 8-byte load, in_valid held high
        exp_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        start_load(11'd8);
        clear_log();
        chk("load_busy", {29'd0, busy, bus.in_ready, cpu_reset}, 32'h7);
        for (int i = 0; i < 8; i++) begin
            send_byte(exp_q[i]);
            if (i == 3) chk("norm_cs_word0", checksum, 32'h20080005);
        end
        bus.in_valid = 1'b0;
        chk("norm_last_we", {bus.mem_we, bus.mem_addr[7:0]}, {1'b1, 8'd7});
        chk("norm_done", {28'd0, done, busy, bus.in_ready, cpu_reset}, 32'h8);
        chk("norm_cs_final", checksum, 32'hCC100005);
        repeat (3) @(negedge clk);
        check_log("norm", 8);

        // Stalls after byte 2 and byte 5; in_valid in DONE must be ignored
        start_load(11'd8);
        clear_log();
        for (int i = 0; i < 8; i++) begin
            send_byte(exp_q[i]);
            if (i == 1) stall(3);
            if (i == 4) stall(5);
        end
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("stall_cs", checksum, 32'hCC100005);
        chk("stall_done", {30'd0, done, cpu_reset}, 32'h2);
        check_log("stall", 8);

        // Bad counts: 0 from DONE, 6 and 1028 from ERR
        clear_log();
        start_load(11'd0);
        chk("bad0_flags", {28'd0, error, done, busy, bus.in_ready}, 32'h8);
        chk("bad0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("bad0_cs_held", checksum, 32'hCC100005);
        start_load(11'd6);
        chk("bad6_flags", {28'd0, error, done, busy, bus.in_ready}, 32'h8);
        start_load(11'd1028);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bad1028_flags", {27'd0, cpu_reset, error, done, busy, bus.in_ready}, 32'h18);
        chk("bad_no_writes", 32'(wa.size()), 32'd0);

        // Reset with the 4th byte presented mid-load
        start_load(11'd8);
        clear_log();
        chk("from_err_load", {29'd0, busy, error, bus.in_ready}, 32'h5);
        for (int i = 0; i < 3; i++) send_byte(exp_q[i]);
        bus.in_data = exp_q[3];
        reset       = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("midrst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("midrst_flags", {27'd0, cpu_reset, busy, done, error, bus.in_ready}, 32'h10);
        chk("midrst_cs", checksum, 32'd0);
        repeat (2) @(negedge clk);
        check_log("midrst", 3);

        // New 4-byte load after reset
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_load(11'd4);
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(exp_q[i]);
        bus.in_valid = 1'b0;
        chk("four_cs", checksum, 32'h11223344);
        chk("four_done", {30'd0, done, cpu_reset}, 32'h2);
        @(negedge clk);
        check_log("four", 4);

        // start during LOAD is ignored
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
        start_load(11'd8);
        clear_log();
        send_byte(exp_q[0]);
        send_byte(exp_q[1]);
        start      = 1'b1;
        byte_count = 11'd4;
        send_byte(exp_q[2]);
        start = 1'b0;
        for (int i = 3; i < 8; i++) send_byte(exp_q[i]);
        bus.in_valid = 1'b0;
        chk("ign_start_cs", checksum, 32'h11223344);
        chk("ign_start_done", {30'd0, done, busy}, 32'h2);
        @(negedge clk);
        check_log("ign_start", 8);

        // Restart from DONE with byte_count=4
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        start_load(11'd4);
        clear_log();
        chk("restart_trans", {28'd0, cpu_reset, busy, done, bus.in_ready}, 32'hD);
        chk("restart_cs_clr", checksum, 32'd0);
        for (int i = 0; i < 4; i++) send_byte(exp_q[i]);
        bus.in_valid = 1'b0;
        chk("restart_cs", checksum, 32'hDEADBEEF);
        @(negedge clk);
        check_log("restart", 4);

        // Full memory load
        exp_q.delete();
        sum = 32'd0;
        w   = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back(8'(i * 7 + 3));
            w = {w[23:0], exp_q[i]};
            if (i % 4 == 3) sum = sum + w;
        end
        start_load(11'd1024);
        clear_log();
        for (int i = 0; i < 1024; i++) send_byte(exp_q[i]);
        bus.in_valid = 1'b0;
        chk("full_last_addr", bus.mem_addr, 32'd1023);
        chk("full_done", {30'd0, done, cpu_reset}, 32'h2);
        chk("full_cs", checksum, sum);
        @(negedge clk);
        check_log("full", 1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
